// File: rtl/alu4_pkg.sv
// Shared definitions for the alu4 issue stage: opcodes, command layout, FSM states.
package alu4_pkg;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    localparam int CMD_W = 10;

    // Operands keep the arithmetic stage's bit order (bit 3 = LSB); never reordered here.
    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
    } alu4_cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_HOLD   = 2'b10
    } alu4_state_e;

endpackage

// File: rtl/alu4_cmd_fifo.sv
// Synchronous command FIFO; a pushed entry becomes readable the cycle after the push.
module alu4_cmd_fifo #(
    parameter int WIDTH = 14,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_s, pop_s;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == {CNT_W{1'b0}});
    assign rd_data = mem_q[rd_ptr_q];
    assign push_s  = push & ~full;
    assign pop_s   = pop & ~empty;

    // Next storage, pointers and occupancy.
    always_comb begin
        mem_d = mem_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu4_issue_stage.sv
// Front-end for the combinational 4-bit add/sub/mul stage: buffer, drive, settle, capture.
// Define ALU4_ISSUE_STATS_EN to add the stat_issued / stat_stall saturating counters.
module alu4_issue_stage
    import alu4_pkg::*;
#(
    parameter int TAG_W         = 4,
    parameter int SETTLE_CYCLES = 1,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [1:0]       alu_op,
    input  logic [7:0]       alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [7:0]       rsp_result,
    output logic [TAG_W-1:0] rsp_tag
`ifdef ALU4_ISSUE_STATS_EN
    ,
    output logic [15:0]      stat_issued,
    output logic [15:0]      stat_stall
`endif
);

    localparam int ENTRY_W = CMD_W + TAG_W;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    logic [ENTRY_W-1:0] fifo_wr_s;
    logic [ENTRY_W-1:0] fifo_rd_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic               push_s;
    logic               pop_s;

    alu4_state_e      state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    alu4_cmd_t        alu_cmd_q, alu_cmd_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_result_q, rsp_result_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;

    assign push_s    = cmd_valid & ~fifo_full_s;
    assign fifo_wr_s = {cmd_tag, cmd_a, cmd_b, cmd_op};

    alu4_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push_s),
        .wr_data (fifo_wr_s),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // Issue FSM next state; alu_* only move when an entry is popped.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        alu_cmd_d    = alu_cmd_q;
        tag_d        = tag_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_tag_d    = rsp_tag_q;
        pop_s        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_s) begin
                    pop_s     = 1'b1;
                    alu_cmd_d = alu4_cmd_t'(fifo_rd_s[CMD_W-1:0]);
                    tag_d     = fifo_rd_s[ENTRY_W-1:CMD_W];
                    cnt_d     = SETTLE_LOAD;
                    state_d   = ST_SETTLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    rsp_result_d = alu_result;
                    rsp_tag_d    = tag_q;
                    rsp_valid_d  = 1'b1;
                    state_d      = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    // Back-to-back issue skips IDLE when work is already queued.
                    if (!fifo_empty_s) begin
                        pop_s     = 1'b1;
                        alu_cmd_d = alu4_cmd_t'(fifo_rd_s[CMD_W-1:0]);
                        tag_d     = fifo_rd_s[ENTRY_W-1:CMD_W];
                        cnt_d     = SETTLE_LOAD;
                        state_d   = ST_SETTLE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    // Issue FSM and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            alu_cmd_q    <= '{a: 4'd0, b: 4'd0, op: OP_NOP};
            tag_q        <= {TAG_W{1'b0}};
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= 8'd0;
            rsp_tag_q    <= {TAG_W{1'b0}};
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            alu_cmd_q    <= alu_cmd_d;
            tag_q        <= tag_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign cmd_ready  = ~fifo_full_s;
    assign alu_a      = alu_cmd_q.a;
    assign alu_b      = alu_cmd_q.b;
    assign alu_op     = alu_cmd_q.op;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_tag    = rsp_tag_q;

`ifdef ALU4_ISSUE_STATS_EN
    logic [15:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_stall_q, stat_stall_d;

    // Saturating issue and back-pressure counters.
    always_comb begin
        if (pop_s && (stat_issued_q != 16'hFFFF)) begin
            stat_issued_d = stat_issued_q + 16'd1;
        end else begin
            stat_issued_d = stat_issued_q;
        end
        if (cmd_valid && fifo_full_s && (stat_stall_q != 16'hFFFF)) begin
            stat_stall_d = stat_stall_q + 16'd1;
        end else begin
            stat_stall_d = stat_stall_q;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q <= 16'd0;
            stat_stall_q  <= 16'd0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_alu4_issue_stage.sv
// Randomized bench for alu4_issue_stage: two instances (settle 1 and 3) checked each cycle
// against a transaction-timing model; define ALU4_ISSUE_STATS_EN to also cover the counters.
module tb_alu4_issue_stage;
    import alu4_pkg::*;

    localparam int TAG_W = 4;
    localparam int DEPTH = 2;
    localparam int NM    = 8192;
    localparam int BIG   = 32'h3FFF_FFFF;

    typedef struct packed {
        logic [3:0]       a;
        logic [3:0]       b;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
    } txn_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic [3:0]       cmd_a = 4'd0;
    logic [3:0]       cmd_b = 4'd0;
    logic [1:0]       cmd_op = 2'd0;
    logic [TAG_W-1:0] cmd_tag = 4'd0;
    logic             rsp_ready = 1'b0;

    logic             cmd_ready [2];
    logic [3:0]       alu_a [2];
    logic [3:0]       alu_b [2];
    logic [1:0]       alu_op [2];
    logic [7:0]       alu_res [2];
    logic             rsp_valid [2];
    logic [7:0]       rsp_result [2];
    logic [TAG_W-1:0] rsp_tag [2];
`ifdef ALU4_ISSUE_STATS_EN
    logic [15:0]      stat_issued [2];
    logic [15:0]      stat_stall [2];
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] rev4(input logic [3:0] x);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = x[3-i];
        return r;
    endfunction

    function automatic logic [7:0] rev8(input logic [7:0] x);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = x[7-i];
        return r;
    endfunction

    // Arithmetic-stage model: operands and result are LSB-first on the wires.
    function automatic logic [7:0] stage(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
        logic [7:0] va, vb, v;
        va = {4'd0, rev4(a)};
        vb = {4'd0, rev4(b)};
        case (op)
            OP_ADD:  v = va + vb;
            OP_SUB:  v = va - vb;
            OP_MUL:  v = va * vb;
            default: v = 8'h5A;
        endcase
        return rev8(v);
    endfunction

    assign alu_res[0] = stage(alu_a[0], alu_b[0], alu_op[0]);
    assign alu_res[1] = stage(alu_a[1], alu_b[1], alu_op[1]);

    alu4_issue_stage #(.TAG_W(TAG_W), .SETTLE_CYCLES(1), .FIFO_DEPTH(DEPTH)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a[0]), .alu_b(alu_b[0]), .alu_op(alu_op[0]), .alu_result(alu_res[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[0]),
        .rsp_tag(rsp_tag[0])
`ifdef ALU4_ISSUE_STATS_EN
        , .stat_issued(stat_issued[0]), .stat_stall(stat_stall[0])
`endif
    );

    alu4_issue_stage #(.TAG_W(TAG_W), .SETTLE_CYCLES(3), .FIFO_DEPTH(DEPTH)) u_dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_a(alu_a[1]), .alu_b(alu_b[1]), .alu_op(alu_op[1]), .alu_result(alu_res[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready), .rsp_result(rsp_result[1]),
        .rsp_tag(rsp_tag[1])
`ifdef ALU4_ISSUE_STATS_EN
        , .stat_issued(stat_issued[1]), .stat_stall(stat_stall[1])
`endif
    );

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (dut%0d) at %0t: got %0h, expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Model: per instance, accept cycles, handshake cycles and the commands, all since last reset.
    txn_t m_cmd [2][NM];
    int   m_acc [2][NM];
    int   m_hs  [2][NM];
    int   n_acc [2];
    int   n_hs  [2];
    int   n_pop [2];
    int   n_stall [2];
    int   cyc = 0;

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Pop of command k: the cycle after it is accepted, but not before the previous response is taken.
    function automatic int pop_time(input int d, input int k);
        int t;
        if (k >= n_acc[d]) return BIG;
        t = m_acc[d][k] + 1;
        if (k == 0) return t;
        if (k - 1 >= n_hs[d]) return BIG;
        return (m_hs[d][k-1] > t) ? m_hs[d][k-1] : t;
    endfunction

    function automatic int sat16(input int v);
        return (v > 65535) ? 65535 : v;
    endfunction

    initial begin
        logic exp_ready, exp_valid;
        txn_t cur, rsp;
        for (int d = 0; d < 2; d++) begin
            n_acc[d] = 0; n_hs[d] = 0; n_pop[d] = 0; n_stall[d] = 0;
        end
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (rst) begin
                    n_acc[d] = 0; n_hs[d] = 0; n_pop[d] = 0; n_stall[d] = 0;
                end else begin
                    while (n_pop[d] < n_acc[d] && pop_time(d, n_pop[d]) < cyc) n_pop[d]++;
                    exp_ready = ((n_acc[d] - n_pop[d]) < DEPTH);
                    exp_valid = (n_hs[d] < n_pop[d]) && (pop_time(d, n_hs[d]) + settle_of(d) + 1 <= cyc);
                    chk("cmd_ready", d, 32'(cmd_ready[d]), 32'(exp_ready));
                    chk("rsp_valid", d, 32'(rsp_valid[d]), 32'(exp_valid));
                    if (exp_valid) begin
                        rsp = m_cmd[d][n_hs[d]];
                        chk("rsp_result", d, 32'(rsp_result[d]), 32'(stage(rsp.a, rsp.b, rsp.op)));
                        chk("rsp_tag", d, 32'(rsp_tag[d]), 32'(rsp.tag));
                    end else if (n_hs[d] == 0) begin
                        chk("rsp_result_rst", d, 32'(rsp_result[d]), 32'd0);
                        chk("rsp_tag_rst", d, 32'(rsp_tag[d]), 32'd0);
                    end
                    cur = (n_pop[d] > 0) ? m_cmd[d][n_pop[d]-1] : '0;
                    chk("alu_a", d, 32'(alu_a[d]), 32'(cur.a));
                    chk("alu_b", d, 32'(alu_b[d]), 32'(cur.b));
                    chk("alu_op", d, 32'(alu_op[d]), 32'(cur.op));
`ifdef ALU4_ISSUE_STATS_EN
                    chk("stat_issued", d, 32'(stat_issued[d]), 32'(sat16(n_pop[d])));
                    chk("stat_stall", d, 32'(stat_stall[d]), 32'(sat16(n_stall[d])));
`endif
                    if (cmd_valid && exp_ready && n_acc[d] < NM) begin
                        m_cmd[d][n_acc[d]] = '{a: cmd_a, b: cmd_b, op: cmd_op, tag: cmd_tag};
                        m_acc[d][n_acc[d]] = cyc;
                        n_acc[d]++;
                    end
                    if (cmd_valid && !exp_ready) n_stall[d]++;
                    if (exp_valid && rsp_ready) begin
                        m_hs[d][n_hs[d]] = cyc;
                        n_hs[d]++;
                    end
                end
            end
            cyc++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cmd(input logic v, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic [TAG_W-1:0] tag);
        cmd_valid = v; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
    endtask

    initial begin
        int last, t;
        repeat (3) step();
        rst = 1'b0;

        // 3 * 2 = 6, LSB-first on both sides; response three cycles after accept on settle=1
        set_cmd(1'b1, 4'b1100, 4'b0100, OP_MUL, 4'd5);
        step();
        cmd_valid = 1'b0;
        step();
        chk("t1 rsp_valid early", 0, 32'(rsp_valid[0]), 32'd0);
        step();
        chk("t1 rsp_valid", 0, 32'(rsp_valid[0]), 32'd1);
        chk("t1 rsp_result", 0, 32'(rsp_result[0]), 32'b01100000);
        chk("t1 rsp_tag", 0, 32'(rsp_tag[0]), 32'd5);
        rsp_ready = 1'b1;
        repeat (6) step();
        rsp_ready = 1'b0;

        // Three back-to-back commands against a stalled response port
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 4'(i + 1), 4'(i + 9), OP_ADD, 4'(i));
            step();
        end
        cmd_valid = 1'b0;
        repeat (5) step();
        chk("t2 fifo full", 0, 32'(cmd_ready[0]), 32'd0);
        chk("t2 held tag", 0, 32'(rsp_tag[0]), 32'd0);
        rsp_ready = 1'b1;
        repeat (20) step();

        // Streaming: one response per settle+1 cycles
        last = -1;
        t = 0;
        begin
            int last1;
            last1 = -1;
            for (int i = 0; i < 48; i++) begin
                set_cmd(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 4'(i));
                step();
                t++;
                if (rsp_valid[1]) begin
                    if (last >= 0) chk("t3 gap settle3", 1, 32'(t - last), 32'd4);
                    last = t;
                end
                if (rsp_valid[0]) begin
                    if (last1 >= 0) chk("t3 gap settle1", 0, 32'(t - last1), 32'd2);
                    last1 = t;
                end
            end
        end
        cmd_valid = 1'b0;
        repeat (20) step();

        // Reset while the settle=3 instance is settling with two commands buffered
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            set_cmd(1'b1, 4'b1010, 4'(i), OP_SUB, 4'(i + 7));
            step();
        end
        cmd_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("t5 rsp_valid", d, 32'(rsp_valid[d]), 32'd0);
            chk("t5 cmd_ready", d, 32'(cmd_ready[d]), 32'd1);
            chk("t5 alu_op", d, 32'(alu_op[d]), 32'(OP_NOP));
        end
        rsp_ready = 1'b1;
        repeat (20) step();

`ifdef ALU4_ISSUE_STATS_EN
        // 3 accepts then 7 stalls, drain, one more command: 4 issues, 7 stalls
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b0;
        set_cmd(1'b1, 4'b0001, 4'b0010, OP_ADD, 4'd1);
        repeat (10) step();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) step();
        set_cmd(1'b1, 4'b0011, 4'b0001, OP_MUL, 4'd2);
        step();
        cmd_valid = 1'b0;
        repeat (6) step();
        chk("t6 stat_issued", 0, 32'(stat_issued[0]), 32'd4);
        chk("t6 stat_stall", 0, 32'(stat_stall[0]), 32'd7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1;
        repeat (65545) step();
        chk("t6 stall saturated", 0, 32'(stat_stall[0]), 32'h0000FFFF);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) step();
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            set_cmd(($urandom_range(0, 3) != 0), 4'($urandom), 4'($urandom), 2'($urandom), 4'($urandom));
            rsp_ready = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
